// File: rtl/dm_access_unit.sv
// -----------------------------------------------------------------------------
// dm_access_unit
//
// Multi-cycle data-memory access engine for the multi-cycle core. Takes one
// load/store request from the datapath (control-decoder encodings MemWrite /
// MemRead / LAddr, ALU byte address, rt store data) and carries it out against
// a word-wide data memory through a req/ack handshake.
//   - sw          : one write beat.
//   - sb / sh     : read-modify-write (one read beat, then one write beat).
//   - loads       : one read beat; result aligned and sign/zero-extended.
//   - misaligned  : aborted without touching memory (misalign flag).
//   - no ack      : beat abandoned after 2^TO_W-1 cycles (timeout flag).
// Byte order is little-endian: byte k of a word is word[8k+7:8k].
//
// Parameters:
//   TO_W      width of the ack-timeout counter
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous, active-high reset
//   start     one-cycle request pulse, only accepted while idle
//   MemWrite  00 none, 01 sw, 10 sb, 11 sh (wins over MemRead)
//   MemRead   1 = load, type selected by LAddr
//   LAddr     000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, others lw
//   addr      byte address
//   wdata     store data
//   busy      high whenever the engine is not idle
//   done      one-cycle completion pulse
//   rdata     formatted load result, held until the next load completes
//   misalign  access aborted for misalignment (valid with done)
//   timeout   access aborted for missing ack (valid with done)
//   m_req     memory request
//   m_we      memory write enable
//   m_addr    word address of the access
//   m_wdata   word to write
//   m_rdata   word read back, valid with m_ack
//   m_ack     beat completion, sampled while m_req is high
// -----------------------------------------------------------------------------
module dm_access_unit #(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  LAddr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_SW,
    OP_SB,
    OP_SH,
    OP_LW,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU
  } op_t;

  // Last count value that still waits; the abort happens on the
  // (2^TO_W-1)-th cycle without an ack.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state;
  state_t          state_next;

  op_t             op_in;
  logic            mis_in;

  op_t             op_q;
  logic [1:0]      off_q;
  logic [15:0]     wdata_q;
  logic [TO_W-1:0] to_cnt;

  logic            is_load;
  logic            start_acc;
  logic            ld_rdata;
  logic            ld_merge;
  logic            to_fire;
  logic            cnt_clr;
  logic            cnt_inc;

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_fmt;
  logic [31:0]     merged;

  // ---------------------------------------------------------------------------
  // Request decode (inputs are only looked at while idle)
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    op_in = OP_NONE;
    case (MemWrite)
      2'b01:   op_in = OP_SW;
      2'b10:   op_in = OP_SB;
      2'b11:   op_in = OP_SH;
      default: begin
        if (MemRead) begin
          case (LAddr)
            3'b001:  op_in = OP_LB;
            3'b010:  op_in = OP_LBU;
            3'b011:  op_in = OP_LH;
            3'b100:  op_in = OP_LHU;
            default: op_in = OP_LW;
          endcase
        end
      end
    endcase
  end

  // Only sw needs word alignment; halfword ops need even addresses. Byte ops
  // and lw never abort.
  always_comb begin
    mis_in = 1'b0;
    case (op_in)
      OP_SW:                 mis_in = (addr[1:0] != 2'b00);
      OP_SH, OP_LH, OP_LHU:  mis_in = addr[0];
      default:               mis_in = 1'b0;
    endcase
  end

  assign is_load = op_q inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked blocks use non-blocking assignments only, so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    start_acc  = 1'b0;
    ld_rdata   = 1'b0;
    ld_merge   = 1'b0;
    to_fire    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          if (mis_in || (op_in == OP_NONE)) begin
            state_next = DONE;
          end else if (op_in == OP_SW) begin
            state_next = WRITE;
            cnt_clr    = 1'b1;
          end else begin
            // sb/sh fetch the word first so the other bytes survive.
            state_next = READ;
            cnt_clr    = 1'b1;
          end
        end
      end

      READ: begin
        // An ack on the terminal-count cycle still completes the beat.
        if (m_ack) begin
          if (is_load) begin
            ld_rdata   = 1'b1;
            state_next = DONE;
          end else begin
            ld_merge   = 1'b1;
            state_next = WRITE;
            cnt_clr    = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          to_fire    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      WRITE: begin
        if (m_ack) begin
          state_next = DONE;
        end else if (to_cnt == TO_LAST) begin
          to_fire    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load formatting and sub-word merge, both straight off the returned word
  // ---------------------------------------------------------------------------
  assign byte_sel = m_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = m_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_fmt = m_rdata;
    case (op_q)
      OP_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_fmt = {24'h000000, byte_sel};
      OP_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_fmt = {16'h0000, half_sel};
      default: load_fmt = m_rdata;
    endcase
  end

  always_comb begin
    merged = m_rdata;
    case (op_q)
      OP_SB:   merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
      OP_SH:   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = m_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_NONE;
      off_q    <= 2'b00;
      wdata_q  <= 16'h0000;
      to_cnt   <= '0;
      rdata    <= 32'h0000_0000;
      m_addr   <= 32'h0000_0000;
      m_wdata  <= 32'h0000_0000;
      misalign <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (cnt_clr) begin
        to_cnt <= '0;
      end else if (cnt_inc) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (start_acc) begin
        op_q     <= op_in;
        off_q    <= addr[1:0];
        wdata_q  <= wdata[15:0];
        m_addr   <= {addr[31:2], 2'b00};
        misalign <= mis_in;
        timeout  <= 1'b0;
        if (op_in == OP_SW) begin
          m_wdata <= wdata;
        end
      end

      if (ld_merge) begin
        m_wdata <= merged;
      end

      if (ld_rdata) begin
        rdata <= load_fmt;
      end

      if (to_fire) begin
        timeout <= 1'b1;
      end
    end
  end

  // Handshake outputs come straight from the state, so m_req/m_we cannot
  // glitch within a beat and drop the cycle after a reset edge.
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign m_req = (state == READ) || (state == WRITE);
  assign m_we  = (state == WRITE);

endmodule
